cpu15_ctrl_core: RTL and testbench

//  CPU15 control core: 4-phase sequencer, instruction decode and execute/PC unit.

---
 rtl/cpu15_pkg.sv | 44 ++++
 rtl/cpu15_phase_gen.sv | 47 ++++
 rtl/cpu15_ctrl_core.sv | 149 ++++++++++++++
 tb/tb_cpu15_ctrl_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu15_pkg.sv
// CPU15 shared definitions: ISA widths, phase encoding and opcode values.
// Optional halt support is selected in the core with the CPU15_HALT_EN macro.
package cpu15_pkg;

  localparam int DATA_W  = 16;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 15;

  typedef enum logic [1:0] {
    PH_FT = 2'd0,
    PH_DC = 2'd1,
    PH_EX = 2'd2,
    PH_WB = 2'd3
  } phase_e;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_SL  = 4'd5;
  localparam logic [3:0] OP_SR  = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_LDL = 4'd8;
  localparam logic [3:0] OP_LDH = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_JE  = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12;
  localparam logic [3:0] OP_LD  = 4'd13;
  localparam logic [3:0] OP_ST  = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Strobe bit order is {WB, EX, DC, FT}.
  function automatic logic [3:0] phase_onehot(input phase_e ph);
    case (ph)
      PH_FT:   return 4'b0001;
      PH_DC:   return 4'b0010;
      PH_EX:   return 4'b0100;
      PH_WB:   return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/cpu15_phase_gen.sv
// CPU15 4-phase sequencer: FT->DC->EX->WB rotation with registered one-hot strobes.
module cpu15_phase_gen
  import cpu15_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  output logic [1:0] phase,
  output logic [3:0] strobe
);

  phase_e     phase_r;
  phase_e     phase_nxt_s;
  logic [3:0] strobe_r;
  logic [3:0] strobe_nxt_s;

  // State register; strobes are registered alongside so they never glitch.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_r  <= PH_FT;
      strobe_r <= 4'b0001;
    end else begin
      phase_r  <= phase_nxt_s;
      strobe_r <= strobe_nxt_s;
    end
  end

  // Next-phase rotation.
  always_comb begin
    phase_nxt_s = PH_FT;
    case (phase_r)
      PH_FT:   phase_nxt_s = PH_DC;
      PH_DC:   phase_nxt_s = PH_EX;
      PH_EX:   phase_nxt_s = PH_WB;
      PH_WB:   phase_nxt_s = PH_FT;
      default: phase_nxt_s = PH_FT;
    endcase
  end

  // Strobe decode of the upcoming phase.
  always_comb begin
    strobe_nxt_s = phase_onehot(phase_nxt_s);
  end

  assign phase  = phase_r;
  assign strobe = strobe_r;

endmodule

// File: rtl/cpu15_ctrl_core.sv
// CPU15 control core: sequencer, decode latch and execute/PC unit.
// Define CPU15_HALT_EN to make HLT a sticky halt; otherwise HLT behaves as a NOP.
module cpu15_ctrl_core
  import cpu15_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [14:0] PROM_OUT,
  input  logic [15:0] REG_A,
  input  logic [15:0] REG_B,
  input  logic [15:0] RAM_OUT,
  output logic        CLK_FT,
  output logic        CLK_DC,
  output logic        CLK_EX,
  output logic        CLK_WB,
  output logic [3:0]  OP_CODE,
  output logic [7:0]  OP_DATA,
  output logic [7:0]  P_COUNT,
  output logic [15:0] REG_IN,
  output logic [15:0] RAM_IN,
  output logic        REG_WEN,
  output logic        RAM_WEN
);

  logic [1:0]  phase_s;
  logic [3:0]  strobe_s;
  logic [3:0]  op_code_r;
  logic [7:0]  op_data_r;
  logic [7:0]  p_count_r, pc_nxt_s;
  logic [15:0] reg_in_r, reg_in_nxt_s;
  logic [15:0] ram_in_r, ram_in_nxt_s;
  logic        reg_wen_r, reg_wen_nxt_s;
  logic        ram_wen_r, ram_wen_nxt_s;
  logic        flag_r, flag_nxt_s;
  logic [2:0]  unused_ra_s;

  // Register selects are decoded by the external register file.
  assign unused_ra_s = PROM_OUT[10:8];

  cpu15_phase_gen u_phase_gen (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .phase   (phase_s),
    .strobe  (strobe_s)
  );

`ifdef CPU15_HALT_EN
  logic halt_r, halt_nxt_s;

  // Sticky halt, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      halt_r <= 1'b0;
    end else if (phase_s == PH_EX) begin
      halt_r <= halt_nxt_s;
    end
  end
`else
  logic halt_r;
  assign halt_r = 1'b0;
`endif

  // Execute: next PC, write-back data, enables and compare flag.
  always_comb begin
    pc_nxt_s      = p_count_r + 8'd1;
    reg_in_nxt_s  = reg_in_r;
    ram_in_nxt_s  = ram_in_r;
    reg_wen_nxt_s = 1'b0;
    ram_wen_nxt_s = 1'b0;
    flag_nxt_s    = flag_r;
`ifdef CPU15_HALT_EN
    halt_nxt_s    = halt_r;
`endif
    if (halt_r) begin
      pc_nxt_s = p_count_r;
    end else begin
      case (op_code_r)
        OP_MOV: begin reg_in_nxt_s = REG_B;                        reg_wen_nxt_s = 1'b1; end
        OP_ADD: begin reg_in_nxt_s = REG_A + REG_B;                reg_wen_nxt_s = 1'b1; end
        OP_SUB: begin reg_in_nxt_s = REG_A - REG_B;                reg_wen_nxt_s = 1'b1; end
        OP_AND: begin reg_in_nxt_s = REG_A & REG_B;                reg_wen_nxt_s = 1'b1; end
        OP_OR:  begin reg_in_nxt_s = REG_A | REG_B;                reg_wen_nxt_s = 1'b1; end
        OP_SL:  begin reg_in_nxt_s = {REG_A[14:0], 1'b0};          reg_wen_nxt_s = 1'b1; end
        OP_SR:  begin reg_in_nxt_s = {1'b0, REG_A[15:1]};          reg_wen_nxt_s = 1'b1; end
        OP_SRA: begin reg_in_nxt_s = {REG_A[15], REG_A[15:1]};     reg_wen_nxt_s = 1'b1; end
        OP_LDL: begin reg_in_nxt_s = {REG_A[15:8], op_data_r};     reg_wen_nxt_s = 1'b1; end
        OP_LDH: begin reg_in_nxt_s = {op_data_r, REG_A[7:0]};      reg_wen_nxt_s = 1'b1; end
        OP_LD:  begin reg_in_nxt_s = RAM_OUT;                      reg_wen_nxt_s = 1'b1; end
        OP_CMP: begin flag_nxt_s = (REG_A == REG_B); end
        OP_JE:  begin
          if (flag_r) begin
            pc_nxt_s = op_data_r;
          end else begin
            pc_nxt_s = p_count_r + 8'd1;
          end
        end
        OP_JMP: begin pc_nxt_s = op_data_r; end
        OP_ST:  begin ram_in_nxt_s = REG_A; ram_wen_nxt_s = 1'b1; end
        OP_HLT: begin
`ifdef CPU15_HALT_EN
          halt_nxt_s = 1'b1;
          pc_nxt_s   = p_count_r;
`endif
        end
        default: begin pc_nxt_s = p_count_r + 8'd1; end
      endcase
    end
  end

  // Decode latch on the DC edge, architectural update on the EX edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_code_r <= 4'd0;
      op_data_r <= 8'd0;
      p_count_r <= 8'd0;
      reg_in_r  <= 16'd0;
      ram_in_r  <= 16'd0;
      reg_wen_r <= 1'b0;
      ram_wen_r <= 1'b0;
      flag_r    <= 1'b0;
    end else begin
      if (phase_s == PH_DC) begin
        op_code_r <= PROM_OUT[14:11];
        op_data_r <= PROM_OUT[7:0];
      end
      if (phase_s == PH_EX) begin
        p_count_r <= pc_nxt_s;
        reg_in_r  <= reg_in_nxt_s;
        ram_in_r  <= ram_in_nxt_s;
        reg_wen_r <= reg_wen_nxt_s;
        ram_wen_r <= ram_wen_nxt_s;
        flag_r    <= flag_nxt_s;
      end
    end
  end

  assign CLK_FT  = strobe_s[0];
  assign CLK_DC  = strobe_s[1];
  assign CLK_EX  = strobe_s[2];
  assign CLK_WB  = strobe_s[3];
  assign OP_CODE = op_code_r;
  assign OP_DATA = op_data_r;
  assign P_COUNT = p_count_r;
  assign REG_IN  = reg_in_r;
  assign RAM_IN  = ram_in_r;
  assign REG_WEN = reg_wen_r;
  assign RAM_WEN = ram_wen_r;

endmodule

// File: tb/tb_cpu15_ctrl_core.sv
// Self-checking bench for cpu15_ctrl_core: directed vector table, corner sequences,
// and random instructions against an arithmetic reference model (honours CPU15_HALT_EN).
module tb_cpu15_ctrl_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] prom_out = 15'd0;
  logic [15:0] reg_a = 16'd0, reg_b = 16'd0, ram_out = 16'd0;
  logic        clk_ft, clk_dc, clk_ex, clk_wb;
  logic [3:0]  op_code;
  logic [7:0]  op_data, p_count;
  logic [15:0] reg_in, ram_in;
  logic        reg_wen, ram_wen;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_pc, m_flag, m_reg_in, m_ram_in, m_reg_wen, m_ram_wen, m_halt;

  cpu15_ctrl_core dut (
    .CLK(clk), .RESET_N(rst_n), .PROM_OUT(prom_out), .REG_A(reg_a), .REG_B(reg_b),
    .RAM_OUT(ram_out), .CLK_FT(clk_ft), .CLK_DC(clk_dc), .CLK_EX(clk_ex), .CLK_WB(clk_wb),
    .OP_CODE(op_code), .OP_DATA(op_data), .P_COUNT(p_count), .REG_IN(reg_in),
    .RAM_IN(ram_in), .REG_WEN(reg_wen), .RAM_WEN(ram_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  data;
    logic [15:0] a, b, ram;
    bit          chk_reg, chk_ram;
    logic [15:0] exp_val;
    logic        exp_reg_wen, exp_ram_wen;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_flag = 0; m_reg_in = 0; m_ram_in = 0;
    m_reg_wen = 0; m_ram_wen = 0; m_halt = 0;
  endtask

  task automatic model_step(input int op, input int data, input int a, input int b, input int ram);
    int npc;
    m_reg_wen = 0;
    m_ram_wen = 0;
    if (m_halt != 0) return;
    npc = (m_pc + 1) % 256;
    case (op)
      0:  begin m_reg_in = b;                              m_reg_wen = 1; end
      1:  begin m_reg_in = (a + b) % 65536;                m_reg_wen = 1; end
      2:  begin m_reg_in = (a - b + 65536) % 65536;        m_reg_wen = 1; end
      3:  begin m_reg_in = a & b;                          m_reg_wen = 1; end
      4:  begin m_reg_in = a | b;                          m_reg_wen = 1; end
      5:  begin m_reg_in = (a * 2) % 65536;                m_reg_wen = 1; end
      6:  begin m_reg_in = a / 2;                          m_reg_wen = 1; end
      7:  begin m_reg_in = a / 2 + ((a >= 32768) ? 32768 : 0); m_reg_wen = 1; end
      8:  begin m_reg_in = (a / 256) * 256 + data;         m_reg_wen = 1; end
      9:  begin m_reg_in = data * 256 + (a % 256);         m_reg_wen = 1; end
      13: begin m_reg_in = ram;                            m_reg_wen = 1; end
      10: m_flag = (a == b) ? 1 : 0;
      11: if (m_flag != 0) npc = data;
      12: npc = data;
      14: begin m_ram_in = a; m_ram_wen = 1; end
      15: begin
`ifdef CPU15_HALT_EN
        m_halt = 1;
        npc = m_pc;
`endif
      end
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Wait for DC phase, present the instruction, then sample in WB after the EX edge.
  task automatic run_instr(input logic [3:0] op, input logic [7:0] data, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] ram);
    int guard = 0;
    while (!clk_dc && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!clk_dc) chk("dc_timeout", 0, 1);
    prom_out = {op, 3'($urandom_range(0, 7)), data};
    reg_a = a; reg_b = b; ram_out = ram;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    model_step(int'(op), int'(data), int'(a), int'(b), int'(ram));
    chk("op_code", int'(op_code), int'(op));
    chk("op_data", int'(op_data), int'(data));
    chk("wb_strobe", int'({clk_wb, clk_ex, clk_dc, clk_ft}), 8);
    chk("p_count", int'(p_count), m_pc);
    chk("reg_in", int'(reg_in), m_reg_in);
    chk("ram_in", int'(ram_in), m_ram_in);
    chk("reg_wen", int'(reg_wen), m_reg_wen);
    chk("ram_wen", int'(ram_wen), m_ram_wen);
  endtask

  initial begin
    logic [7:0] pc_hold;
    logic [3:0] op_r;
    logic [15:0] a_r;

    //          op     data   a        b        ram      chk_reg chk_ram exp      rwen  mwen  pc
    tbl[0]  = '{4'd8,  8'h34, 16'h1200, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 8'h01};
    tbl[1]  = '{4'd9,  8'h56, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h5634, 1'b1, 1'b0, 8'h02};
    tbl[2]  = '{4'd1,  8'h00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h03};
    tbl[3]  = '{4'd7,  8'h00, 16'h8002, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hC001, 1'b1, 1'b0, 8'h04};
    tbl[4]  = '{4'd6,  8'h00, 16'h8002, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h4001, 1'b1, 1'b0, 8'h05};
    tbl[5]  = '{4'd5,  8'h00, 16'h8002, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 8'h06};
    tbl[6]  = '{4'd2,  8'h00, 16'h0003, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 8'h07};
    tbl[7]  = '{4'd3,  8'h00, 16'hF0F0, 16'hFF00, 16'h0000, 1'b1, 1'b0, 16'hF000, 1'b1, 1'b0, 8'h08};
    tbl[8]  = '{4'd4,  8'h00, 16'hF0F0, 16'hFF00, 16'h0000, 1'b1, 1'b0, 16'hFFF0, 1'b1, 1'b0, 8'h09};
    tbl[9]  = '{4'd0,  8'h00, 16'h0000, 16'h1357, 16'h0000, 1'b1, 1'b0, 16'h1357, 1'b1, 1'b0, 8'h0A};
    tbl[10] = '{4'd13, 8'h20, 16'h0000, 16'h0000, 16'hABCD, 1'b1, 1'b0, 16'hABCD, 1'b1, 1'b0, 8'h0B};
    tbl[11] = '{4'd10, 8'h00, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'hABCD, 1'b0, 1'b0, 8'h0C};
    tbl[12] = '{4'd11, 8'h10, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h10};
    tbl[13] = '{4'd10, 8'h00, 16'h0005, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h11};
    tbl[14] = '{4'd11, 8'h10, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h12};
    tbl[15] = '{4'd14, 8'h00, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 8'h13};
    tbl[16] = '{4'd12, 8'hFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'hFF};
    tbl[17] = '{4'd0,  8'h00, 16'h0000, 16'h2468, 16'h0000, 1'b1, 1'b0, 16'h2468, 1'b1, 1'b0, 8'h00};

    // reset values while held
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", int'({clk_wb, clk_ex, clk_dc, clk_ft}), 1);
    chk("rst_pc", int'(p_count), 0);
    chk("rst_opcode", int'(op_code), 0);
    chk("rst_opdata", int'(op_data), 0);
    chk("rst_reg_in", int'(reg_in), 0);
    chk("rst_ram_in", int'(ram_in), 0);
    chk("rst_wens", int'({reg_wen, ram_wen}), 0);

    // phase rotation from release
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("strobe_seq", int'({clk_wb, clk_ex, clk_dc, clk_ft}), 1 << (i % 4));
      @(negedge clk);
    end

    // directed table
    do_reset();
    for (int i = 0; i < 18; i++) begin
      run_instr(tbl[i].op, tbl[i].data, tbl[i].a, tbl[i].b, tbl[i].ram);
      if (tbl[i].chk_reg) chk("tbl_reg_in", int'(reg_in), int'(tbl[i].exp_val));
      if (tbl[i].chk_ram) chk("tbl_ram_in", int'(ram_in), int'(tbl[i].exp_val));
      chk("tbl_reg_wen", int'(reg_wen), int'(tbl[i].exp_reg_wen));
      chk("tbl_ram_wen", int'(ram_wen), int'(tbl[i].exp_ram_wen));
      chk("tbl_pc", int'(p_count), int'(tbl[i].exp_pc));
    end

    // flag survives intervening non-CMP ops
    run_instr(4'd10, 8'h00, 16'h0077, 16'h0077, 16'h0000);
    run_instr(4'd1, 8'h00, 16'h0001, 16'h0002, 16'h0000);
    run_instr(4'd14, 8'h00, 16'h1111, 16'h0000, 16'h0000);
    run_instr(4'd11, 8'h40, 16'h0000, 16'h0000, 16'h0000);
    chk("je_late_flag", int'(p_count), 8'h40);

    // reset in the middle of an instruction
    while (!clk_dc) @(negedge clk);
    prom_out = {4'd12, 3'd0, 8'h99};
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pc", int'(p_count), 0);
    chk("midrst_strobe", int'({clk_wb, clk_ex, clk_dc, clk_ft}), 1);
    chk("midrst_wens", int'({reg_wen, ram_wen}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_instr(4'd1, 8'h00, 16'h0010, 16'h0020, 16'h0000);
    chk("midrst_restart_pc", int'(p_count), 1);

    // random instructions against the model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      op_r = 4'($urandom_range(0, 14));
      a_r = 16'($urandom);
      run_instr(op_r, 8'($urandom), a_r, ($urandom_range(0, 2) == 0) ? a_r : 16'($urandom),
                16'($urandom));
    end

    // HLT behaviour
    do_reset();
    run_instr(4'd8, 8'h11, 16'h2200, 16'h0000, 16'h0000);
    run_instr(4'd15, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    chk("hlt_wens", int'({reg_wen, ram_wen}), 0);
    pc_hold = p_count;
`ifdef CPU15_HALT_EN
    chk("hlt_pc_frozen", int'(pc_hold), 1);
`else
    chk("hlt_pc_nop", int'(pc_hold), 2);
`endif
    for (int i = 0; i < 25; i++) begin
      run_instr(4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom));
`ifdef CPU15_HALT_EN
      chk("halt_pc_hold", int'(p_count), int'(pc_hold));
      chk("halt_wens", int'({reg_wen, ram_wen}), 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
